// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer that sits in front of the arithmetic unit and owns the register file.
// Optional retire counter output is built when ALU_SEQUENCER_RETIRE_CNT_EN is defined.

// state  | meaning
// IDLE   | ready for an instruction; operands are latched on accept
// MEMRD  | memory read strobe issued at the latched immediate address
// MEMCAP | read data captured into the memory operand
// ISSUE  | one-cycle start pulse to the arithmetic unit
// WAIT   | operands held; result written to rd when the unit reports valid

module alu_sequencer #(
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INSTR_VALID,
    output logic          INSTR_READY,
    input  logic [1:0]    INSTR_OP,
    input  logic [1:0]    INSTR_MOVI,
    input  logic [RW-1:0] INSTR_RD,
    input  logic [RW-1:0] INSTR_RA,
    input  logic [RW-1:0] INSTR_RB,
    input  logic [31:0]   INSTR_IMM,
    output logic          MEM_RE,
    output logic [31:0]   MEM_ADDR,
    input  logic [31:0]   MEM_RDATA,
    output logic          AU_ACT,
    output logic [1:0]    AU_OP_CODE,
    output logic [1:0]    AU_MOVI,
    output logic [31:0]   AU_REG_A,
    output logic [31:0]   AU_REG_B,
    output logic [31:0]   AU_MEM,
    output logic [31:0]   AU_IMM,
    input  logic [31:0]   AU_DATA,
    input  logic          AU_DATA_VALID,
    input  logic [RW-1:0] DBG_ADDR,
    output logic [31:0]   DBG_DATA,
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
    output logic [31:0]   RETIRE_CNT,
`endif
    output logic          BUSY
);

    localparam logic [1:0] MOVI_MEM = 2'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEMRD  = 3'd1,
        MEMCAP = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          cap_mem;
    logic          wb_en;

    logic [1:0]    op_q;
    logic [1:0]    movi_q;
    logic [RW-1:0] rd_q;
    logic [31:0]   imm_q;
    logic [31:0]   reg_a_q;
    logic [31:0]   reg_b_q;
    logic [31:0]   mem_q;

    logic [31:0]   rf [NREGS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        INSTR_READY = 1'b0;
        BUSY        = 1'b1;
        MEM_RE      = 1'b0;
        AU_ACT      = 1'b0;
        accept      = 1'b0;
        cap_mem     = 1'b0;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                INSTR_READY = 1'b1;
                BUSY        = 1'b0;
                if (INSTR_VALID) begin
                    accept    = 1'b1;
                    state_nxt = (INSTR_MOVI == MOVI_MEM) ? MEMRD : ISSUE;
                end
            end
            MEMRD: begin
                MEM_RE    = 1'b1;
                state_nxt = MEMCAP;
            end
            MEMCAP: begin
                cap_mem   = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                AU_ACT    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (AU_DATA_VALID) begin
                    wb_en     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers only change on accept/capture, so the unit sees
    // stable inputs for the whole ISSUE..WAIT window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q    <= '0;
            movi_q  <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            mem_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q    <= INSTR_OP;
                movi_q  <= INSTR_MOVI;
                rd_q    <= INSTR_RD;
                imm_q   <= INSTR_IMM;
                reg_a_q <= rf[INSTR_RA];
                reg_b_q <= rf[INSTR_RB];
            end
            if (cap_mem) begin
                mem_q <= MEM_RDATA;
            end
            if (wb_en) begin
                rf[rd_q] <= AU_DATA;
            end
        end
    end

`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RETIRE_CNT <= '0;
        end else if (wb_en) begin
            RETIRE_CNT <= RETIRE_CNT + 32'd1;
        end
    end
`endif

    assign MEM_ADDR   = MEM_RE ? imm_q : 32'd0;
    assign AU_OP_CODE = op_q;
    assign AU_MOVI    = movi_q;
    assign AU_REG_A   = reg_a_q;
    assign AU_REG_B   = reg_b_q;
    assign AU_MEM     = mem_q;
    assign AU_IMM     = imm_q;

    // Reads the register array directly: a same-cycle writeback is not bypassed.
    assign DBG_DATA   = rf[DBG_ADDR];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random instructions against a cycle-level model.
// Also checks RETIRE_CNT when built with ALU_SEQUENCER_RETIRE_CNT_EN.

module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [1:0]  INSTR_OP = '0;
    logic [1:0]  INSTR_MOVI = '0;
    logic [2:0]  INSTR_RD = '0;
    logic [2:0]  INSTR_RA = '0;
    logic [2:0]  INSTR_RB = '0;
    logic [31:0] INSTR_IMM = '0;
    logic        MEM_RE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_RDATA = '0;
    logic        AU_ACT;
    logic [1:0]  AU_OP_CODE;
    logic [1:0]  AU_MOVI;
    logic [31:0] AU_REG_A;
    logic [31:0] AU_REG_B;
    logic [31:0] AU_MEM;
    logic [31:0] AU_IMM;
    logic [31:0] AU_DATA = '0;
    logic        AU_DATA_VALID = 1'b0;
    logic [2:0]  DBG_ADDR = '0;
    logic [31:0] DBG_DATA;
    logic        BUSY;
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
    logic [31:0] RETIRE_CNT;
`endif

    alu_sequencer #(.NREGS(8)) dut (
        .CLK(CLK), .RST(RST),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .INSTR_OP(INSTR_OP), .INSTR_MOVI(INSTR_MOVI),
        .INSTR_RD(INSTR_RD), .INSTR_RA(INSTR_RA), .INSTR_RB(INSTR_RB),
        .INSTR_IMM(INSTR_IMM),
        .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .AU_ACT(AU_ACT), .AU_OP_CODE(AU_OP_CODE), .AU_MOVI(AU_MOVI),
        .AU_REG_A(AU_REG_A), .AU_REG_B(AU_REG_B), .AU_MEM(AU_MEM), .AU_IMM(AU_IMM),
        .AU_DATA(AU_DATA), .AU_DATA_VALID(AU_DATA_VALID),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA),
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
        .RETIRE_CNT(RETIRE_CNT),
`endif
        .BUSY(BUSY)
    );

    always #10 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en   = 1'b0;
    bit dbg_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 32'd0) ? 32'd0 : a / b;
        endcase
    endfunction

    function automatic logic [31:0] mem_func(input logic [31:0] addr);
        return (addr == 32'h40) ? 32'd7 : ((addr * 32'h9E3779B1) ^ 32'h5A5A_0F0F);
    endfunction

    // ---------------- environment: arithmetic unit and memory ----------------
    initial begin : au_resp
        logic [31:0] b;
        int n;
        forever begin
            @(negedge CLK);
            if (AU_ACT === 1'b1) begin
                n = (AU_OP_CODE == 2'd2) ? 5 : 2;
                repeat (n) @(posedge CLK);
                #1;
                case (AU_MOVI)
                    2'd0:    b = AU_REG_B;
                    2'd1:    b = AU_MEM;
                    2'd2:    b = AU_IMM;
                    default: b = 32'd0;
                endcase
                AU_DATA       = alu_ref(AU_OP_CODE, AU_REG_A, b);
                AU_DATA_VALID = 1'b1;
                @(posedge CLK);
                #1;
                AU_DATA_VALID = 1'b0;
                AU_DATA       = $urandom;
            end
        end
    end

    initial begin : mem_resp
        logic [31:0] v;
        forever begin
            @(negedge CLK);
            if (MEM_RE === 1'b1) begin
                v = mem_func(MEM_ADDR);
                @(posedge CLK);
                #1 MEM_RDATA = v;
                @(posedge CLK);
                #1 MEM_RDATA = $urandom;
            end
        end
    end

    always @(posedge CLK) begin
        if (dbg_rand) #1 DBG_ADDR = 3'($urandom);
    end

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_rf [8];
    bit          m_busy = 1'b0;
    int          m_c, m_l, m_off;
    logic [1:0]  m_op, m_movi;
    logic [2:0]  m_rd;
    logic [31:0] m_imm, m_a, m_b, m_memv, m_res;
    logic [31:0] m_retire = '0;

    always @(posedge CLK) begin
        logic [31:0] bsel;
        if (RST) begin
            for (int i = 0; i < 8; i++) mdl_rf[i] = '0;
            m_busy   = 1'b0;
            m_retire = '0;
        end else if (m_busy) begin
            m_c++;
            if (m_c == m_l) begin
                mdl_rf[m_rd] = m_res;
                m_retire     = m_retire + 32'd1;
                m_busy       = 1'b0;
            end
        end else if (INSTR_VALID) begin
            m_op   = INSTR_OP;
            m_movi = INSTR_MOVI;
            m_rd   = INSTR_RD;
            m_imm  = INSTR_IMM;
            m_a    = mdl_rf[INSTR_RA];
            m_b    = mdl_rf[INSTR_RB];
            m_memv = mem_func(INSTR_IMM);
            case (INSTR_MOVI)
                2'd0:    bsel = m_b;
                2'd1:    bsel = m_memv;
                2'd2:    bsel = m_imm;
                default: bsel = 32'd0;
            endcase
            m_res  = alu_ref(m_op, m_a, bsel);
            m_off  = (m_movi == 2'd1) ? 2 : 0;
            m_l    = m_off + ((m_op == 2'd2) ? 6 : 3);
            m_c    = 0;
            m_busy = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", {31'd0, BUSY}, {31'd0, m_busy});
            check("instr_ready", {31'd0, INSTR_READY}, {31'd0, !m_busy});
            check("au_act", {31'd0, AU_ACT}, {31'd0, m_busy && (m_c == m_off)});
            check("mem_re", {31'd0, MEM_RE}, {31'd0, m_busy && (m_movi == 2'd1) && (m_c == 0)});
            if (m_busy && m_movi == 2'd1 && m_c == 0) check("mem_addr", MEM_ADDR, m_imm);
            if (m_busy && m_c >= m_off) begin
                check("au_op_code", {30'd0, AU_OP_CODE}, {30'd0, m_op});
                check("au_movi", {30'd0, AU_MOVI}, {30'd0, m_movi});
                check("au_reg_a", AU_REG_A, m_a);
                check("au_reg_b", AU_REG_B, m_b);
                check("au_imm", AU_IMM, m_imm);
                if (m_movi == 2'd1) check("au_mem", AU_MEM, m_memv);
            end
            check("dbg_data", DBG_DATA, mdl_rf[DBG_ADDR]);
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
            check("retire_cnt", RETIRE_CNT, m_retire);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [1:0] movi, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] imm,
                         input bit hold);
        bit rdy;
        bit done;
        @(posedge CLK);
        #1;
        INSTR_OP = op; INSTR_MOVI = movi; INSTR_RD = rd;
        INSTR_RA = ra; INSTR_RB = rb; INSTR_IMM = imm;
        INSTR_VALID = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            rdy = INSTR_READY;
            @(posedge CLK);
            #1;
            if (rdy) done = 1'b1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) begin
            INSTR_VALID = 1'b0;
            INSTR_OP = 2'($urandom); INSTR_MOVI = 2'($urandom);
            INSTR_RD = 3'($urandom); INSTR_RA = 3'($urandom);
            INSTR_RB = 3'($urandom); INSTR_IMM = $urandom;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (!BUSY) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic dbg_sweep(input string name, input logic [31:0] exp [8]);
        dbg_rand = 1'b0;
        @(posedge CLK);
        for (int k = 0; k < 8; k++) begin
            #1 DBG_ADDR = 3'(k);
            #1 check(name, DBG_DATA, exp[k]);
        end
        dbg_rand = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] zeros [8];
        logic [31:0] vals  [8];
        int n_busy, n_act, act_at, n_re;
        bit done;
        for (int i = 0; i < 8; i++) zeros[i] = '0;

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk_en = 1'b1;

        dbg_sweep("reset_rf", zeros);
        check("reset_ready", {31'd0, INSTR_READY}, 32'd1);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_au_reg_a", AU_REG_A, 32'd0);
        check("reset_au_imm", AU_IMM, 32'd0);
        check("reset_mem_addr", MEM_ADDR, 32'd0);

        // ADD r1 = r0 + 5
        issue(2'd0, 2'd2, 3'd1, 3'd0, 3'd0, 32'd5, 1'b0);
        n_busy = 0; n_act = 0; act_at = 0; done = 1'b0;
        for (int c = 1; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (AU_ACT) begin n_act++; act_at = c; end
            if (BUSY) n_busy++; else done = 1'b1;
        end
        check("add_act_count", n_act, 32'd1);
        check("add_act_cycle", act_at, 32'd1);
        check("add_busy_cycles", n_busy, 32'd3);

        // MUL r2 = r1 * r1
        issue(2'd2, 2'd0, 3'd2, 3'd1, 3'd1, 32'hDEAD_BEEF, 1'b0);
        n_busy = 0; done = 1'b0;
        for (int c = 1; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (BUSY) begin
                n_busy++;
                check("mul_reg_a_stable", AU_REG_A, 32'd5);
                check("mul_reg_b_stable", AU_REG_B, 32'd5);
            end else done = 1'b1;
        end
        check("mul_busy_cycles", n_busy, 32'd6);

        // SUB r3 = r2 - mem[0x40]
        issue(2'd1, 2'd1, 3'd3, 3'd2, 3'd0, 32'h40, 1'b0);
        n_busy = 0; n_re = 0; done = 1'b0;
        for (int c = 1; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (MEM_RE) begin
                n_re++;
                check("sub_mem_addr", MEM_ADDR, 32'h40);
            end
            if (BUSY) n_busy++; else done = 1'b1;
        end
        check("sub_mem_re_count", n_re, 32'd1);
        check("sub_busy_cycles", n_busy, 32'd5);

        // DIV r4 = r3 / r0 with INSTR_VALID held through the whole operation
        issue(2'd3, 2'd0, 3'd4, 3'd3, 3'd0, 32'd0, 1'b1);
        n_act = 0; done = 1'b0;
        for (int c = 1; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (AU_ACT) n_act++;
            if (!BUSY) begin
                INSTR_VALID = 1'b0;
                done = 1'b1;
            end
        end
        check("div_single_accept", n_act, 32'd1);

        // rd == ra: r1 = r1 + 3
        issue(2'd0, 2'd2, 3'd1, 3'd1, 3'd7, 32'd3, 1'b0);
        wait_idle();
        vals = '{32'd0, 32'd8, 32'd25, 32'd18, 32'd0, 32'd0, 32'd0, 32'd0};
        dbg_sweep("directed_rf", vals);
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
        check("retire_after_directed", RETIRE_CNT, 32'd5);
`endif

        // Reset while a MUL sits in WAIT
        issue(2'd2, 2'd0, 3'd5, 3'd2, 3'd2, 32'd0, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ready", {31'd0, INSTR_READY}, 32'd1);
        check("rst_au_reg_a", AU_REG_A, 32'd0);
        dbg_sweep("rst_rf", zeros);
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
        check("rst_retire", RETIRE_CNT, 32'd0);
`endif
        repeat (8) @(posedge CLK);
        dbg_sweep("late_valid_ignored", zeros);

        // Random instructions, sometimes offered back to back while busy
        for (int t = 0; t < 60; t++) begin
            issue(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge CLK);
            end
        end
        wait_idle();
        repeat (2) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
